// File: rtl/apb_accum_pair.sv
// APB-style master/slave pair around a 32-bit accumulator peripheral.
// Define APB_WAIT_STATE_EN to add one wait state to every slave access.
module apb_accum_master #(
    parameter int DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              transfer,
    input  logic              PREADY,
    input  logic [DATA_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PDATA,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PRWADDR,
    output logic [DATA_W-1:0] PRWDATA
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD
    } state_t;

    state_t state, state_n;
    logic   load;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state   <= IDLE;
            PRWADDR <= '0;
            PRWDATA <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                PRWADDR <= PADDR;
                PRWDATA <= PDATA;
            end
        end
    end

    // HOLD parks the master until PSEL drops: one transfer per assertion
    always_comb begin
        state_n = state;
        PENABLE = 1'b0;
        load    = 1'b0;
        unique case (state)
            IDLE: begin
                if (PSEL && transfer) begin
                    state_n = SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                state_n = PSEL ? ACCESS : IDLE;
            end
            ACCESS: begin
                PENABLE = 1'b1;
                if (!PSEL)
                    state_n = IDLE;
                else if (PREADY)
                    state_n = HOLD;
            end
            HOLD: begin
                if (!PSEL)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

module apb_accum_slave #(
    parameter int DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [1:0]        func,
    input  logic [DATA_W-1:0] PRWDATA,
    output logic [DATA_W-1:0] PRDATA1,
    output logic              PREADY
);

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_n;
    logic [DATA_W-1:0] diff_up;
    logic [DATA_W-1:0] diff_dn;
    logic              done;

`ifdef APB_WAIT_STATE_EN
    logic waited;

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)
            waited <= 1'b0;
        else
            waited <= PSEL & PENABLE & ~waited;
    end

    assign PREADY = PSEL & PENABLE & waited;
`else
    assign PREADY = PSEL & PENABLE;
`endif

    assign done    = PSEL & PENABLE & PREADY;
    assign diff_up = PRWDATA - acc;
    assign diff_dn = acc - PRWDATA;

    // SUB yields sign-magnitude: MSB is the sign, low bits the magnitude
    always_comb begin
        acc_n = acc;
        unique case (func)
            2'b00: acc_n = PRWDATA;
            2'b01: acc_n = acc + PRWDATA;
            2'b10: acc_n = acc ^ PRWDATA;
            2'b11: begin
                if (PRWDATA > acc)
                    acc_n = {1'b1, diff_up[DATA_W-2:0]};
                else
                    acc_n = {1'b0, diff_dn[DATA_W-2:0]};
            end
            default: acc_n = acc;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            acc     <= '0;
            PRDATA1 <= '0;
        end else if (done) begin
            if (PWRITE) begin
                acc     <= acc_n;
                PRDATA1 <= acc_n;
            end else begin
                PRDATA1 <= acc;
            end
        end
    end

endmodule

module apb_accum_pair #(
    parameter int DATA_W = 32
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              transfer,
    input  logic              PWRITE,
    input  logic [DATA_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PDATA,
    output logic              PENABLE,
    output logic [DATA_W-1:0] PRWDATA,
    output logic [DATA_W-1:0] PRWADDR,
    output logic [DATA_W-1:0] PRDATA1,
    output logic              PREADY
);

    apb_accum_master #(
        .DATA_W(DATA_W)
    ) master (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .transfer(transfer),
        .PREADY  (PREADY),
        .PADDR   (PADDR),
        .PDATA   (PDATA),
        .PENABLE (PENABLE),
        .PRWADDR (PRWADDR),
        .PRWDATA (PRWDATA)
    );

    apb_accum_slave #(
        .DATA_W(DATA_W)
    ) slave (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PWRITE (PWRITE),
        .func   (PRWADDR[3:2]),
        .PRWDATA(PRWDATA),
        .PRDATA1(PRDATA1),
        .PREADY (PREADY)
    );

endmodule

// File: tb/tb_apb_accum_pair.sv
// Randomized self-checking bench for apb_accum_pair.
// Compares against a plain arithmetic accumulator model.
module tb_apb_accum_pair;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        transfer;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PDATA;
    logic        PENABLE;
    logic [31:0] PRWDATA;
    logic [31:0] PRWADDR;
    logic [31:0] PRDATA1;
    logic        PREADY;

    int checks = 0;
    int errors = 0;

    logic [31:0] acc_m;

`ifdef APB_WAIT_STATE_EN
    localparam int EN_CYC = 2;
`else
    localparam int EN_CYC = 1;
`endif

    apb_accum_pair #(
        .DATA_W(32)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .transfer(transfer),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PDATA   (PDATA),
        .PENABLE (PENABLE),
        .PRWDATA (PRWDATA),
        .PRWADDR (PRWADDR),
        .PRDATA1 (PRDATA1),
        .PREADY  (PREADY)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns what a completed transfer should show on the read port
    function automatic logic [31:0] model_op(input logic w,
                                            input logic [31:0] a,
                                            input logic [31:0] d);
        if (!w)
            return acc_m;
        case (a[3:2])
            2'd0: acc_m = d;
            2'd1: acc_m = acc_m + d;
            2'd2: acc_m = acc_m ^ d;
            default: begin
                if (d > acc_m)
                    acc_m = 32'h8000_0000 | ((d - acc_m) & 32'h7fff_ffff);
                else
                    acc_m = (acc_m - d) & 32'h7fff_ffff;
            end
        endcase
        return acc_m;
    endfunction

    task automatic xfer(input string tag, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input int hold);
        int          en_cnt;
        logic [31:0] exp;
        en_cnt = 0;
        @(negedge PCLK);
        PSEL = 1'b1;
        transfer = 1'b1;
        PWRITE = w;
        PADDR = a;
        PDATA = d;
        for (int i = 0; i < hold; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (PENABLE)
                en_cnt++;
            if (i == 0) begin
                PADDR = $urandom;
                PDATA = $urandom;
            end
        end
        PSEL = 1'b0;
        transfer = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        exp = model_op(w, a, d);
        check({tag, "_rdata"}, PRDATA1, exp);
        check({tag, "_en"}, 32'(en_cnt), 32'(EN_CYC));
        check({tag, "_addr"}, PRWADDR, a);
        check({tag, "_data"}, PRWDATA, d);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] snap_d;
        logic [31:0] snap_a;
        int          en_cnt;

        PRESET = 1'b0;
        PSEL = 1'b0;
        transfer = 1'b0;
        PWRITE = 1'b0;
        PADDR = '0;
        PDATA = '0;
        acc_m = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_rdata", PRDATA1, 32'h0);
        check("rst_addr", PRWADDR, 32'h0);
        check("rst_wdata", PRWDATA, 32'h0);
        check("rst_en", {31'h0, PENABLE}, 32'h0);
        check("rst_ready", {31'h0, PREADY}, 32'h0);
        PRESET = 1'b1;

        xfer("load7", 1'b1, 32'h0, 32'd7, 4);
        xfer("add7", 1'b1, 32'h4, 32'd7, 4);
        xfer("xor", 1'b1, 32'h8, 32'h2000_0001, 4);
        xfer("load7b", 1'b1, 32'h0, 32'd7, 4);
        xfer("sub_neg", 1'b1, 32'hC, 32'd12, 4);
        xfer("load12", 1'b1, 32'h0, 32'd12, 4);
        xfer("sub_pos", 1'b1, 32'hC, 32'd7, 4);
        xfer("sub_eq", 1'b1, 32'hFFFF_FFFC, 32'd5, 5);

        // abort in SETUP: no enable, no accumulator change
        @(negedge PCLK);
        PSEL = 1'b1;
        transfer = 1'b1;
        PWRITE = 1'b1;
        PADDR = 32'h0;
        PDATA = 32'hDEAD_BEEF;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_en_setup", {31'h0, PENABLE}, 32'h0);
        PSEL = 1'b0;
        transfer = 1'b0;
        @(posedge PCLK);
        @(negedge PCLK);
        check("abort_en_idle", {31'h0, PENABLE}, 32'h0);
        xfer("read_abort", 1'b0, 32'h4, 32'h1234, 4);

        // PSEL without transfer request never starts anything
        snap_d = PRDATA1;
        snap_a = PRWADDR;
        en_cnt = 0;
        @(negedge PCLK);
        PSEL = 1'b1;
        transfer = 1'b0;
        PWRITE = 1'b1;
        PADDR = 32'h4;
        PDATA = 32'h55;
        repeat (5) begin
            @(posedge PCLK);
            @(negedge PCLK);
            if (PENABLE)
                en_cnt++;
        end
        PSEL = 1'b0;
        check("notx_en", 32'(en_cnt), 32'h0);
        check("notx_addr", PRWADDR, snap_a);
        check("notx_rdata", PRDATA1, snap_d);
        xfer("read_notx", 1'b0, 32'h0, 32'h0, 4);

        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            d = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
            xfer("rand", 1'($urandom_range(0, 3) != 0), a, d,
                 4 + $urandom_range(0, 3));
        end

        // reset while in ACCESS discards the transfer
        @(negedge PCLK);
        PSEL = 1'b1;
        transfer = 1'b1;
        PWRITE = 1'b1;
        PADDR = 32'h4;
        PDATA = 32'd99;
        @(posedge PCLK);
        @(posedge PCLK);
        #2;
        PRESET = 1'b0;
        #1;
        acc_m = '0;
        check("mid_rst_en", {31'h0, PENABLE}, 32'h0);
        check("mid_rst_rdata", PRDATA1, 32'h0);
        check("mid_rst_addr", PRWADDR, 32'h0);
        check("mid_rst_ready", {31'h0, PREADY}, 32'h0);
        PSEL = 1'b0;
        transfer = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b1;
        xfer("post_rst_read", 1'b0, 32'h0, 32'h0, 4);
        xfer("post_rst_add", 1'b1, 32'h4, 32'd3, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
